// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the staged reset sequencer.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    RUN,
    ASSERT,
    RELEASE
  } rst_seq_state_e;

  localparam int unsigned TRIG_CNT_W = 8;

  // Counter width able to hold values 0..v-1, never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v < 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/btn_debouncer.sv
// Two-flop synchroniser plus stable-sample debouncer; rise pulses with each
// accepted low-to-high change of the debounced level.
module btn_debouncer
  import rst_seq_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise
);

  localparam int unsigned CW = clog2_min1(DEBOUNCE_CYCLES);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      dout  <= 1'b0;
      rise  <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      rise  <= 1'b0;
      // cnt tracks how many consecutive samples have disagreed with dout
      if (sync2 == dout) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        dout <= sync2;
        rise <= sync2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/rst_sequencer.sv
// Multi-channel reset sequencer: holds targeted active-low resets, then
// releases channel k at HOLD_CYCLES + k*STAGE_GAP cycles after sequence start.
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int unsigned NUM_CH          = 4,
  parameter int unsigned HOLD_CYCLES     = 16,
  parameter int unsigned STAGE_GAP       = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  btn_in,
  input  logic                  ext_rst_req,
  input  logic                  sw_trigger,
  input  logic [NUM_CH-1:0]     ch_mask,
  output logic [NUM_CH-1:0]     rst_n_out,
  output logic                  seq_busy,
  output logic                  seq_done,
  output logic [TRIG_CNT_W-1:0] trigger_count
);

  localparam int unsigned HW = clog2_min1(HOLD_CYCLES);
  localparam int unsigned SW = clog2_min1(STAGE_GAP);
  localparam int unsigned IW = clog2_min1(NUM_CH + 1);

  rst_seq_state_e  state, state_n;
  logic [HW-1:0]   hold_cnt, hold_n;
  logic [SW-1:0]   slot_cnt, slot_n;
  logic [IW-1:0]   ch_idx, idx_n;
  logic [NUM_CH-1:0] target, target_n, out_n, trig_mask;
  logic [TRIG_CNT_W-1:0] count_n;
  logic            ext_prev;
  logic            btn_rise;
  logic            trig_sw, trig_ext, trig_any;

  btn_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk (clk),
    .rst (rst),
    .din (btn_in),
    .dout(),
    .rise(btn_rise)
  );

  assign seq_busy = (state != RUN);
  assign seq_done = (state == RELEASE) && (ch_idx == IW'(NUM_CH));

  always_comb begin
    trig_sw   = sw_trigger && (|ch_mask);
    trig_ext  = ext_rst_req && !ext_prev;
    trig_any  = trig_sw || btn_rise || trig_ext;
    trig_mask = {NUM_CH{btn_rise || trig_ext}} | ({NUM_CH{trig_sw}} & ch_mask);

    state_n  = state;
    hold_n   = hold_cnt;
    slot_n   = slot_cnt;
    idx_n    = ch_idx;
    target_n = target;
    out_n    = rst_n_out;
    count_n  = trigger_count;

    if (trig_any && (trigger_count != '1))
      count_n = trigger_count + TRIG_CNT_W'(1);

    if (ext_rst_req) begin
      state_n  = ASSERT;
      hold_n   = '0;
      target_n = '1;
      out_n    = '0;
    end else if (trig_any) begin
      // A trigger while busy widens the running target instead of replacing it
      state_n  = ASSERT;
      hold_n   = '0;
      target_n = (seq_busy ? target : '0) | trig_mask;
      out_n    = rst_n_out & ~target_n;
    end else begin
      case (state)
        RUN: ;
        ASSERT: begin
          out_n = rst_n_out & ~target;
          if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
            out_n[0] = out_n[0] | target[0];
            state_n  = RELEASE;
            slot_n   = '0;
            idx_n    = IW'(1);
          end else begin
            hold_n = hold_cnt + HW'(1);
          end
        end
        RELEASE: begin
          if (ch_idx == IW'(NUM_CH)) begin
            state_n = RUN;
          end else if (slot_cnt == SW'(STAGE_GAP - 1)) begin
            for (int unsigned k = 0; k < NUM_CH; k++)
              if (ch_idx == IW'(k)) out_n[k] = out_n[k] | target[k];
            idx_n  = ch_idx + IW'(1);
            slot_n = '0;
          end else begin
            slot_n = slot_cnt + SW'(1);
          end
        end
        default: state_n = ASSERT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ASSERT;
      hold_cnt      <= '0;
      slot_cnt      <= '0;
      ch_idx        <= '0;
      target        <= '1;
      rst_n_out     <= '0;
      trigger_count <= '0;
      ext_prev      <= 1'b0;
    end else begin
      state         <= state_n;
      hold_cnt      <= hold_n;
      slot_cnt      <= slot_n;
      ch_idx        <= idx_n;
      target        <= target_n;
      rst_n_out     <= out_n;
      trigger_count <= count_n;
      ext_prev      <= ext_rst_req;
    end
  end

endmodule

// File: tb/tb_rst_sequencer.sv
// Scoreboard bench for rst_sequencer: a timeline model predicts every cycle's
// outputs, a monitor compares them on the falling edge.
module tb_rst_sequencer;

  localparam int NCH  = 4;
  localparam int HOLD = 16;
  localparam int GAP  = 8;
  localparam int DEB  = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           btn_in = 1'b0;
  logic           ext_rst_req = 1'b0;
  logic           sw_trigger = 1'b0;
  logic [NCH-1:0] ch_mask = '0;
  logic [NCH-1:0] rst_n_out;
  logic           seq_busy;
  logic           seq_done;
  logic [7:0]     trigger_count;

  rst_sequencer #(
    .NUM_CH         (NCH),
    .HOLD_CYCLES    (HOLD),
    .STAGE_GAP      (GAP),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_in       (btn_in),
    .ext_rst_req  (ext_rst_req),
    .sw_trigger   (sw_trigger),
    .ch_mask      (ch_mask),
    .rst_n_out    (rst_n_out),
    .seq_busy     (seq_busy),
    .seq_done     (seq_done),
    .trigger_count(trigger_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int             tag;
    logic [NCH-1:0] out;
    logic           busy;
    logic           done;
    logic [7:0]     cnt;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Model: a sequence is fully described by its start cycle, its target set
  // and the levels untargeted channels had when it started.
  int             t0 = 0;
  logic [NCH-1:0] tgt = '1;
  logic [NCH-1:0] base = '0;
  int             m_cnt = 0;
  logic           m_ext_prev = 1'b0;
  logic           b1 = 1'b0, b2 = 1'b0, lvl = 1'b0, pend = 1'b0;
  int             run_len = 0;

  function automatic int done_cyc();
    return t0 + HOLD + (NCH - 1) * GAP;
  endfunction

  function automatic logic [NCH-1:0] m_out(input int d);
    logic [NCH-1:0] r;
    r = base;
    for (int k = 0; k < NCH; k++)
      if (tgt[k] && (d >= t0 + HOLD + k * GAP)) r[k] = 1'b1;
    return r;
  endfunction

  task automatic step();
    int             c;
    logic           s, bt, tsw, text, any, busy;
    logic [NCH-1:0] mask, cur;
    exp_t           e;
    c = cyc;
    if (rst) begin
      t0 = c + 1; tgt = '1; base = '0; m_cnt = 0; m_ext_prev = 1'b0;
      b1 = 1'b0; b2 = 1'b0; lvl = 1'b0; run_len = 0; pend = 1'b0;
    end else begin
      bt = pend; pend = 1'b0;
      s = b2; b2 = b1; b1 = btn_in;
      if (s != lvl) begin
        run_len++;
        if (run_len == DEB) begin lvl = s; run_len = 0; pend = s; end
      end else run_len = 0;
      tsw  = sw_trigger && (ch_mask != '0);
      text = ext_rst_req && !m_ext_prev;
      m_ext_prev = ext_rst_req;
      any = tsw || bt || text;
      if (ext_rst_req) begin
        t0 = c + 1; tgt = '1; base = '0;
      end else if (any) begin
        cur  = m_out(c);
        busy = (c <= done_cyc());
        mask = ((bt || text) ? 4'hF : 4'h0) | (tsw ? ch_mask : 4'h0);
        tgt  = (busy ? tgt : 4'h0) | mask;
        base = cur & ~tgt;
        t0   = c + 1;
      end
      if (any && m_cnt < 255) m_cnt++;
    end
    e.tag  = c + 1;
    e.out  = m_out(c + 1);
    e.busy = (c + 1) <= done_cyc();
    e.done = (c + 1) == done_cyc();
    e.cnt  = 8'(m_cnt);
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].tag < cyc) begin
      e = q.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL stale_entry: cycle %0d expectation never compared (now %0d)", e.tag, cyc);
    end
    if (q.size() > 0 && q[0].tag == cyc) begin
      e = q.pop_front();
      n_checks++;
      if (rst_n_out !== e.out) begin
        n_fail++;
        $display("FAIL rst_n_out cycle %0d: got %b expected %b", cyc, rst_n_out, e.out);
      end
      n_checks++;
      if (seq_busy !== e.busy) begin
        n_fail++;
        $display("FAIL seq_busy cycle %0d: got %b expected %b", cyc, seq_busy, e.busy);
      end
      n_checks++;
      if (seq_done !== e.done) begin
        n_fail++;
        $display("FAIL seq_done cycle %0d: got %b expected %b", cyc, seq_done, e.done);
      end
      n_checks++;
      if (trigger_count !== e.cnt) begin
        n_fail++;
        $display("FAIL trigger_count cycle %0d: got %0d expected %0d", cyc, trigger_count, e.cnt);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      step();
      @(posedge clk);
      #1;
      sw_trigger = 1'b0;
    end
  endtask

  task automatic sw(input logic [NCH-1:0] m);
    sw_trigger = 1'b1;
    ch_mask    = m;
    tick(1);
  endtask

  initial begin
    @(posedge clk);
    #1;
    rst = 1'b1; tick(3);
    rst = 1'b0; tick(60);                       // power-on sequence
    sw(4'b0110); tick(50);                      // partial software sequence
    btn_in = 1'b1; tick(3); btn_in = 1'b0; tick(20);
    btn_in = 1'b1; tick(10); btn_in = 1'b0; tick(70);
    sw(4'b0001); tick(20); sw(4'b1000); tick(70);
    sw(4'b0000); tick(5);                       // empty mask is ignored
    sw(4'b1111); tick(25);
    ext_rst_req = 1'b1; tick(50); ext_rst_req = 1'b0; tick(60);
    sw(4'b1111); tick(20);
    rst = 1'b1; tick(1); rst = 1'b0; tick(60);
    repeat (260) sw(4'b0011);                   // drive the counter into saturation
    tick(60);
    rst = 1'b1; tick(2); rst = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      sw_trigger = ($urandom_range(0, 39) == 0);
      ch_mask    = NCH'($urandom);
      if ($urandom_range(0, 24) == 0) btn_in = ~btn_in;
      if (ext_rst_req) begin
        if ($urandom_range(0, 29) == 0) ext_rst_req = 1'b0;
      end else if ($urandom_range(0, 299) == 0) ext_rst_req = 1'b1;
      rst = ($urandom_range(0, 999) == 0);
      tick(1);
    end
    rst = 1'b0; ext_rst_req = 1'b0; sw_trigger = 1'b0;
    tick(5);
    @(negedge clk);
    #1;
    if (n_fail == 0) $display("PASS");
    else $display("FAIL");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
